obj_dma: RTL and testbench

Object-RAM DMA writer for the Taito SJ object bus: on a start request it takes the Z80 bus, copies a LEN-byte sprite attribute table from work memory into one bank of object RAM, then releases the bus. It drives the same CPU-side object RAM port the Z80 uses (address, data, OBJRQ, WR, all active-low strobes). The scanline object hardware reads that bank back, so the block offloads per-frame sprite-table copies from the CPU.

---
 rtl/obj_dma.sv | 149 ++++++++++++++
 tb/tb_obj_dma.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obj_dma.sv
// Object-RAM DMA writer: takes the Z80 bus, copies LEN bytes from work memory
// into one object RAM bank through the CPU-side port, then releases the bus.
module obj_dma #(
  parameter int LEN       = 128,
  parameter int WR_CYCLES = 2
) (
  input  logic        clkm_32MHZ,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] src_base,
  input  logic        bank,
  output logic        busrq_n,
  input  logic        busak_n,
  output logic [15:0] src_addr,
  output logic        src_rd,
  input  logic [7:0]  src_data,
  output logic [7:0]  OBJ_A,
  output logic [7:0]  OBJ_D,
  output logic        OBJRQ,
  output logic        OBJ_WR,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, REQ, READ, LATCH, SETUP, STROBE, HOLD, RELEASE
  } state_t;

  localparam logic [6:0] LAST_IDX    = 7'(LEN - 1);
  localparam logic [2:0] STROBE_LAST = 3'(WR_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_base;
  logic        r_bank;
  logic [6:0]  r_idx;
  logic [2:0]  r_wrCnt;
  logic        r_busrqN;
  logic [15:0] r_srcAddr;
  logic        r_srcRd;
  logic [7:0]  r_objA;
  logic [7:0]  r_objD;
  logic        r_objRq;
  logic        r_objWr;
  logic        r_busy;
  logic        r_done;

  logic [6:0]  w_nextIdx;
  logic [15:0] w_nextAddr;

  // Source address for the following byte; wraps naturally at 64K.
  assign w_nextIdx  = r_idx + 7'd1;
  assign w_nextAddr = r_base + {9'd0, w_nextIdx};

  // Outputs are set on the transition into the state that owns them, so each
  // output register already holds the value its new state requires.
  always_ff @(posedge clkm_32MHZ) begin
    if (reset) begin
      r_state   <= IDLE;
      r_base    <= 16'd0;
      r_bank    <= 1'b0;
      r_idx     <= 7'd0;
      r_wrCnt   <= 3'd0;
      r_busrqN  <= 1'b1;
      r_srcAddr <= 16'd0;
      r_srcRd   <= 1'b0;
      r_objA    <= 8'd0;
      r_objD    <= 8'd0;
      r_objRq   <= 1'b1;
      r_objWr   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base   <= src_base;
            r_bank   <= bank;
            r_idx    <= 7'd0;
            r_busrqN <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= REQ;
          end
        end
        REQ: begin
          if (!busak_n) begin
            r_srcRd   <= 1'b1;
            r_srcAddr <= r_base;
            r_state   <= READ;
          end
        end
        READ: begin
          r_srcRd <= 1'b0;
          r_state <= LATCH;
        end
        LATCH: begin
          r_objD  <= src_data;
          r_objA  <= {r_bank, r_idx};
          r_objRq <= 1'b0;
          r_state <= SETUP;
        end
        SETUP: begin
          r_objWr <= 1'b0;
          r_wrCnt <= STROBE_LAST;
          r_state <= STROBE;
        end
        STROBE: begin
          if (r_wrCnt == 3'd0) begin
            r_objWr <= 1'b1;
            r_state <= HOLD;
          end else begin
            r_wrCnt <= r_wrCnt - 3'd1;
          end
        end
        HOLD: begin
          r_objRq <= 1'b1;
          if (r_idx == LAST_IDX) begin
            r_busrqN <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= RELEASE;
          end else begin
            r_idx     <= w_nextIdx;
            r_srcRd   <= 1'b1;
            r_srcAddr <= w_nextAddr;
            r_state   <= READ;
          end
        end
        RELEASE: begin
          if (busak_n) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busrq_n  = r_busrqN;
  assign src_addr = r_srcAddr;
  assign src_rd   = r_srcRd;
  assign OBJ_A    = r_objA;
  assign OBJ_D    = r_objD;
  assign OBJRQ    = r_objRq;
  assign OBJ_WR   = r_objWr;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_obj_dma.sv
// Directed testbench for obj_dma: a LEN=4 instance for the short scenarios and
// a LEN=128 instance for the full-bank copy with source address wrap.
module tb_obj_dma;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  logic        a_start = 1'b0, a_bank = 1'b0, a_busrq_n, a_busak_n = 1'b1, a_src_rd;
  logic        a_OBJRQ, a_OBJ_WR, a_busy, a_done;
  logic [15:0] a_src_base = 16'd0, a_src_addr;
  logic [7:0]  a_src_data = 8'd0, a_OBJ_A, a_OBJ_D;

  logic        b_start = 1'b0, b_bank = 1'b0, b_busrq_n, b_busak_n = 1'b1, b_src_rd;
  logic        b_OBJRQ, b_OBJ_WR, b_busy, b_done;
  logic [15:0] b_src_base = 16'd0, b_src_addr;
  logic [7:0]  b_src_data = 8'd0, b_OBJ_A, b_OBJ_D;

  logic [7:0] mem [0:65535];
  int testsRun = 0;
  int testsFailed = 0;
  int cycle = 0;
  int aGrantDelay = 2;
  int aReqCnt = 0;
  int bReqCnt = 0;

  logic [15:0] aWrites[$], aSetups[$], aHolds[$], aReads[$];
  int aWrLens[$], aRqLens[$];
  int aDoneCnt = 0;
  logic [15:0] bWrites[$], bReads[$];
  int bDoneCnt = 0, bFirstRdCycle = 0, bDoneCycle = 0;

  obj_dma #(.LEN(4), .WR_CYCLES(2)) dutA (
    .clkm_32MHZ(clk), .reset(reset), .start(a_start), .src_base(a_src_base),
    .bank(a_bank), .busrq_n(a_busrq_n), .busak_n(a_busak_n), .src_addr(a_src_addr),
    .src_rd(a_src_rd), .src_data(a_src_data), .OBJ_A(a_OBJ_A), .OBJ_D(a_OBJ_D),
    .OBJRQ(a_OBJRQ), .OBJ_WR(a_OBJ_WR), .busy(a_busy), .done(a_done)
  );

  obj_dma #(.LEN(128), .WR_CYCLES(2)) dutB (
    .clkm_32MHZ(clk), .reset(reset), .start(b_start), .src_base(b_src_base),
    .bank(b_bank), .busrq_n(b_busrq_n), .busak_n(b_busak_n), .src_addr(b_src_addr),
    .src_rd(b_src_rd), .src_data(b_src_data), .OBJ_A(b_OBJ_A), .OBJ_D(b_OBJ_D),
    .OBJRQ(b_OBJRQ), .OBJ_WR(b_OBJ_WR), .busy(b_busy), .done(b_done)
  );

  // Work memory answers a read one cycle later; the Z80 grants after a delay
  // and drops the grant one cycle after the request goes away.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (a_src_rd) a_src_data <= mem[a_src_addr];
    if (b_src_rd) b_src_data <= mem[b_src_addr];
    aReqCnt   <= a_busrq_n ? 0 : aReqCnt + 1;
    a_busak_n <= a_busrq_n ? 1'b1 : ((aReqCnt >= aGrantDelay) ? 1'b0 : 1'b1);
    bReqCnt   <= b_busrq_n ? 0 : bReqCnt + 1;
    b_busak_n <= b_busrq_n ? 1'b1 : ((bReqCnt >= 2) ? 1'b0 : 1'b1);
  end

  // Bus monitor: logs reads, write strobes, strobe/select widths and done pulses.
  initial begin
    logic aPrevRq, aPrevWr, bPrevWr;
    int aRqRun, aWrRun;
    aPrevRq = 1'b1; aPrevWr = 1'b1; bPrevWr = 1'b1; aRqRun = 0; aWrRun = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        aPrevRq = 1'b1; aPrevWr = 1'b1; bPrevWr = 1'b1; aRqRun = 0; aWrRun = 0;
      end else begin
        if (a_done) aDoneCnt++;
        if (a_src_rd) aReads.push_back(a_src_addr);
        if (!a_OBJRQ && aPrevRq) aSetups.push_back({a_OBJ_A, a_OBJ_D});
        if (!a_OBJ_WR && aPrevWr) aWrites.push_back({a_OBJ_A, a_OBJ_D});
        if (a_OBJ_WR && !aPrevWr) begin
          aWrLens.push_back(aWrRun);
          aHolds.push_back({a_OBJ_A, a_OBJ_D});
          aWrRun = 0;
        end
        if (a_OBJRQ && !aPrevRq) begin
          aRqLens.push_back(aRqRun);
          aRqRun = 0;
        end
        if (!a_OBJ_WR) aWrRun++;
        if (!a_OBJRQ) aRqRun++;
        aPrevRq = a_OBJRQ;
        aPrevWr = a_OBJ_WR;
        if (b_src_rd) begin
          if (bReads.size() == 0) bFirstRdCycle = cycle;
          bReads.push_back(b_src_addr);
        end
        if (!b_OBJ_WR && bPrevWr && !b_OBJRQ) bWrites.push_back({b_OBJ_A, b_OBJ_D});
        if (b_done) begin
          bDoneCnt++;
          bDoneCycle = cycle;
        end
        bPrevWr = b_OBJ_WR;
      end
    end
  end

  task automatic clearA();
    aWrites.delete(); aSetups.delete(); aHolds.delete(); aReads.delete();
    aWrLens.delete(); aRqLens.delete();
    aDoneCnt = 0;
  endtask

  task automatic aStart(input logic [15:0] base, input logic bk);
    @(negedge clk);
    a_src_base = base; a_bank = bk; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic aWaitIdle(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!a_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int viol;
    viol = 0;
    reset = 1'b1; a_start = 1'b1; b_start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (a_busrq_n !== 1'b1 || a_busy !== 1'b0 || b_busrq_n !== 1'b1) viol++;
    end
    testsRun++; if (viol !== 0) begin testsFailed++; $display("[TB] FAIL reset_no_request: got %0d violations expected 0", viol); end
    testsRun++; if (a_busrq_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_busrq_n: got %b expected 1", a_busrq_n); end
    testsRun++; if (a_src_rd !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_src_rd: got %b expected 0", a_src_rd); end
    testsRun++; if (a_src_addr !== 16'h0000) begin testsFailed++; $display("[TB] FAIL reset_src_addr: got %h expected 0000", a_src_addr); end
    testsRun++; if (a_OBJ_A !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_OBJ_A: got %h expected 00", a_OBJ_A); end
    testsRun++; if (a_OBJ_D !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_OBJ_D: got %h expected 00", a_OBJ_D); end
    testsRun++; if (a_OBJRQ !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_OBJRQ: got %b expected 1", a_OBJRQ); end
    testsRun++; if (a_OBJ_WR !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_OBJ_WR: got %b expected 1", a_OBJ_WR); end
    testsRun++; if (a_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", a_done); end
    testsRun++; if (b_busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_b_busy: got %b expected 0", b_busy); end
    reset = 1'b0; a_start = 1'b0; b_start = 1'b0;
    @(negedge clk);
    testsRun++; if (a_busrq_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_after_busrq_n: got %b expected 1", a_busrq_n); end
  endtask

  task automatic test_basic_copy();
    logic [7:0] expD [4];
    logic [15:0] expW;
    logic ok;
    expD = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) mem[16'hC000 + i] = expD[i];
    clearA();
    aGrantDelay = 2;
    aStart(16'hC000, 1'b1);
    testsRun++; if (a_busrq_n !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_request_latency: got %b expected 0", a_busrq_n); end
    testsRun++; if (a_busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_busy: got %b expected 1", a_busy); end
    aWaitIdle(200, ok);
    testsRun++; if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_timeout: got %b expected 1", ok); end
    repeat (3) @(negedge clk);
    testsRun++; if (aDoneCnt !== 1) begin testsFailed++; $display("[TB] FAIL basic_done_count: got %0d expected 1", aDoneCnt); end
    testsRun++; if (a_busrq_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_busrq_release: got %b expected 1", a_busrq_n); end
    testsRun++; if (aWrites.size() !== 4) begin testsFailed++; $display("[TB] FAIL basic_write_count: got %0d expected 4", aWrites.size()); end
    for (int i = 0; i < 4; i++) begin
      expW = {8'(8'h80 + i), expD[i]};
      if (i < aWrites.size()) begin
        testsRun++; if (aWrites[i] !== expW) begin testsFailed++; $display("[TB] FAIL basic_write%0d: got %h expected %h", i, aWrites[i], expW); end
      end
      if (i < aSetups.size() && i < aHolds.size()) begin
        testsRun++; if (aSetups[i] !== expW || aHolds[i] !== expW) begin testsFailed++; $display("[TB] FAIL basic_stable%0d: got setup %h hold %h expected %h", i, aSetups[i], aHolds[i], expW); end
      end
      if (i < aWrLens.size() && i < aRqLens.size()) begin
        testsRun++; if (aWrLens[i] !== 2 || aRqLens[i] !== 4) begin testsFailed++; $display("[TB] FAIL basic_widths%0d: got wr %0d rq %0d expected wr 2 rq 4", i, aWrLens[i], aRqLens[i]); end
      end
      if (i < aReads.size()) begin
        testsRun++; if (aReads[i] !== 16'(16'hC000 + i)) begin testsFailed++; $display("[TB] FAIL basic_read%0d: got %h expected %h", i, aReads[i], 16'(16'hC000 + i)); end
      end
    end
  endtask

  task automatic test_grant_stall();
    int stallCnt, viol;
    logic granted, ok;
    stallCnt = 0; viol = 0; granted = 1'b0;
    for (int i = 0; i < 4; i++) mem[16'h1000 + i] = 8'(8'hA0 + i);
    clearA();
    aGrantDelay = 20;
    aStart(16'h1000, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (!a_busak_n) begin
        granted = 1'b1;
        break;
      end
      if (a_src_rd || !a_OBJRQ) viol++;
      if (!a_busrq_n) stallCnt++;
      @(negedge clk);
    end
    testsRun++; if (granted !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_grant_seen: got %b expected 1", granted); end
    testsRun++; if (viol !== 0) begin testsFailed++; $display("[TB] FAIL stall_quiet_bus: got %0d violations expected 0", viol); end
    testsRun++; if ((stallCnt >= 20) !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_length: got %0d cycles expected at least 20", stallCnt); end
    testsRun++; if (a_src_rd !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_rd_early: got %b expected 0", a_src_rd); end
    @(negedge clk);
    testsRun++; if (a_src_rd !== 1'b1 || a_src_addr !== 16'h1000) begin testsFailed++; $display("[TB] FAIL stall_first_read: got rd %b addr %h expected rd 1 addr 1000", a_src_rd, a_src_addr); end
    aWaitIdle(200, ok);
    repeat (2) @(negedge clk);
    testsRun++; if (aWrites.size() !== 4 || ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_writes: got %0d writes idle %b expected 4 writes idle 1", aWrites.size(), ok); end
    aGrantDelay = 2;
  endtask

  task automatic test_back_to_back();
    logic ok, seenLow, seenHigh;
    clearA();
    aStart(16'hC000, 1'b1);
    seenLow = 1'b0; seenHigh = 1'b0;
    for (int i = 0; i < 100 && !seenHigh; i++) begin
      @(negedge clk);
      if (!a_OBJ_WR) seenLow = 1'b1;
      else if (seenLow) seenHigh = 1'b1;
    end
    testsRun++; if (seenHigh !== 1'b1) begin testsFailed++; $display("[TB] FAIL busy_first_strobe: got %b expected 1", seenHigh); end
    repeat (2) @(negedge clk);
    a_src_base = 16'h0000; a_bank = 1'b0; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    aWaitIdle(200, ok);
    testsRun++; if (ok !== 1'b1 || a_busak_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL busy_release: got idle %b busak_n %b expected 1 1", ok, a_busak_n); end
    repeat (10) @(negedge clk);
    testsRun++; if (aWrites.size() !== 4) begin testsFailed++; $display("[TB] FAIL busy_write_count: got %0d expected 4", aWrites.size()); end
    testsRun++; if (aDoneCnt !== 1) begin testsFailed++; $display("[TB] FAIL busy_done_count: got %0d expected 1", aDoneCnt); end
    testsRun++; if (a_busrq_n !== 1'b1 || a_busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL busy_no_requeue: got busrq_n %b busy %b expected 1 0", a_busrq_n, a_busy); end
    if (aWrites.size() == 4) begin
      testsRun++; if (aWrites[3] !== 16'h8344) begin testsFailed++; $display("[TB] FAIL busy_last_write: got %h expected 8344", aWrites[3]); end
    end
  endtask

  task automatic test_reset_mid();
    logic ok, hit;
    hit = 1'b0;
    clearA();
    aStart(16'h3000, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!a_OBJ_WR) begin
        hit = 1'b1;
        break;
      end
    end
    testsRun++; if (hit !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_reach_strobe: got %b expected 1", hit); end
    reset = 1'b1;
    @(negedge clk);
    testsRun++; if (a_OBJRQ !== 1'b1 || a_OBJ_WR !== 1'b1 || a_busrq_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_outputs: got rq %b wr %b busrq_n %b expected 1 1 1", a_OBJRQ, a_OBJ_WR, a_busrq_n); end
    testsRun++; if (a_busy !== 1'b0 || a_OBJ_A !== 8'h00 || a_OBJ_D !== 8'h00) begin testsFailed++; $display("[TB] FAIL rstmid_regs: got busy %b A %h D %h expected 0 00 00", a_busy, a_OBJ_A, a_OBJ_D); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    testsRun++; if (aDoneCnt !== 0) begin testsFailed++; $display("[TB] FAIL rstmid_no_done: got %0d expected 0", aDoneCnt); end
    mem[16'h2000] = 8'h5A; mem[16'h2001] = 8'h6B; mem[16'h2002] = 8'h7C; mem[16'h2003] = 8'h8D;
    clearA();
    aStart(16'h2000, 1'b0);
    aWaitIdle(200, ok);
    repeat (3) @(negedge clk);
    testsRun++; if (ok !== 1'b1 || aDoneCnt !== 1 || aWrites.size() !== 4) begin testsFailed++; $display("[TB] FAIL rstmid_restart: got idle %b done %0d writes %0d expected 1 1 4", ok, aDoneCnt, aWrites.size()); end
    if (aReads.size() > 0) begin
      testsRun++; if (aReads[0] !== 16'h2000) begin testsFailed++; $display("[TB] FAIL rstmid_first_read: got %h expected 2000", aReads[0]); end
    end
    if (aWrites.size() == 4) begin
      testsRun++; if (aWrites[0] !== 16'h005A || aWrites[3] !== 16'h038D) begin testsFailed++; $display("[TB] FAIL rstmid_writes: got %h %h expected 005a 038d", aWrites[0], aWrites[3]); end
    end
  endtask

  task automatic test_full_bank();
    logic [15:0] addr, expW;
    logic ok;
    int errs;
    ok = 1'b0; errs = 0;
    for (int i = 0; i < 128; i++) begin
      addr = 16'(16'hFFC0 + i);
      mem[addr] = addr[7:0] ^ 8'h3C;
    end
    bReads.delete(); bWrites.delete(); bDoneCnt = 0;
    @(negedge clk);
    b_src_base = 16'hFFC0; b_bank = 1'b0; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!b_busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    testsRun++; if (ok !== 1'b1 || bDoneCnt !== 1) begin testsFailed++; $display("[TB] FAIL bank_complete: got idle %b done %0d expected 1 1", ok, bDoneCnt); end
    testsRun++; if (bReads.size() !== 128 || bWrites.size() !== 128) begin testsFailed++; $display("[TB] FAIL bank_counts: got reads %0d writes %0d expected 128 128", bReads.size(), bWrites.size()); end
    testsRun++; if (bDoneCycle - bFirstRdCycle !== 768) begin testsFailed++; $display("[TB] FAIL bank_duration: got %0d cycles expected 768", bDoneCycle - bFirstRdCycle); end
    for (int i = 0; i < 128; i++) begin
      addr = 16'(16'hFFC0 + i);
      expW = {8'(i), addr[7:0] ^ 8'h3C};
      if (i < bReads.size() && bReads[i] !== addr) begin
        if (errs < 4) $display("[TB] FAIL bank_read%0d: got %h expected %h", i, bReads[i], addr);
        errs++;
      end
      if (i < bWrites.size() && bWrites[i] !== expW) begin
        if (errs < 4) $display("[TB] FAIL bank_write%0d: got %h expected %h", i, bWrites[i], expW);
        errs++;
      end
    end
    testsRun++; if (errs !== 0) begin testsFailed++; $display("[TB] FAIL bank_sequence: got %0d bad entries expected 0", errs); end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_grant_stall();
    test_back_to_back();
    test_reset_mid();
    test_full_bank();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 50000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
